vga_timing_ctrl: RTL and testbench



---
 rtl/vga_timing_ctrl_pkg.sv | 40 ++++
 rtl/vga_axis_timer.sv | 47 ++++
 rtl/vga_timing_ctrl.sv | 157 +++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_ctrl_pkg.sv
// Shared types and constants for the VGA timing controller: axis timing record,
// 640x480@60 defaults and the timing legality rule.
package vga_timing_ctrl_pkg;

    localparam int VGA_CNT_W  = 11;
    localparam int VGA_AXIS_W = 4 * VGA_CNT_W;

    typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

    // Field order matches the cfg bus layout, active in the MSBs.
    typedef struct packed {
        vga_cnt_t active;
        vga_cnt_t sync_start;
        vga_cnt_t sync_end;
        vga_cnt_t total;
    } vga_axis_t;

    typedef enum logic {
        SHD_EMPTY = 1'b0,
        SHD_FULL  = 1'b1
    } shd_state_t;

    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_SYNC_START = 656;
    localparam int VGA_H_SYNC_END   = 752;
    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_SYNC_START = 490;
    localparam int VGA_V_SYNC_END   = 492;
    localparam int VGA_V_TOTAL      = 525;

    function automatic logic vga_axis_legal(input vga_axis_t t);
        return (t.active >= vga_cnt_t'(1))
            && (t.active <= t.sync_start)
            && (t.sync_start < t.sync_end)
            && (t.sync_end <= t.total)
            && (t.total >= vga_cnt_t'(2));
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: counter with programmable wrap plus sync-window and
// active-region decode of the current count.
module vga_axis_timer
    import vga_timing_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  step,
    input  logic [VGA_AXIS_W-1:0] timing,
    output logic [VGA_CNT_W-1:0]  cnt,
    output logic                  wrap,
    output logic                  in_sync,
    output logic                  in_active
);

    vga_axis_t t;
    vga_cnt_t  cnt_q;
    vga_cnt_t  cnt_d;
    logic      last;

    assign t    = vga_axis_t'(timing);
    assign last = (cnt_q == t.total - vga_cnt_t'(1));
    assign wrap = en && step && last;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = last ? '0 : cnt_q + vga_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign in_sync   = (cnt_q >= t.sync_start) && (cnt_q < t.sync_end);
    assign in_active = (cnt_q < t.active);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: h/v pixel counters, registered sync/de decode, and a
// shadowed timing set that only switches on a frame boundary or while stopped.
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_SYNC_START = VGA_H_SYNC_START,
    parameter int H_SYNC_END   = VGA_H_SYNC_END,
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_SYNC_START = VGA_V_SYNC_START,
    parameter int V_SYNC_END   = VGA_V_SYNC_END,
    parameter int V_TOTAL      = VGA_V_TOTAL,
    parameter bit SYNC_POL     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [VGA_AXIS_W-1:0] cfg_h,
    input  logic [VGA_AXIS_W-1:0] cfg_v,
    output logic                  cfg_err,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [VGA_CNT_W-1:0]  pix_x,
    output logic [VGA_CNT_W-1:0]  pix_y,
    output logic                  frame_start
);

    localparam vga_axis_t H_RST = '{
        active:     vga_cnt_t'(H_ACTIVE),
        sync_start: vga_cnt_t'(H_SYNC_START),
        sync_end:   vga_cnt_t'(H_SYNC_END),
        total:      vga_cnt_t'(H_TOTAL)
    };
    localparam vga_axis_t V_RST = '{
        active:     vga_cnt_t'(V_ACTIVE),
        sync_start: vga_cnt_t'(V_SYNC_START),
        sync_end:   vga_cnt_t'(V_SYNC_END),
        total:      vga_cnt_t'(V_TOTAL)
    };

    vga_axis_t  live_h, live_v;
    vga_axis_t  shd_h, shd_v;
    shd_state_t shd_state, shd_state_d;

    logic       cfg_ok, cfg_accept;
    logic       apply_edge, load_shd, load_live;

    vga_cnt_t   h_cnt, v_cnt;
    logic       h_wrap, v_wrap;
    logic       h_sync, v_sync;
    logic       h_act, v_act;

    vga_axis_timer u_h_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .step      (1'b1),
        .timing    (live_h),
        .cnt       (h_cnt),
        .wrap      (h_wrap),
        .in_sync   (h_sync),
        .in_active (h_act)
    );

    vga_axis_timer u_v_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .step      (h_wrap),
        .timing    (live_v),
        .cnt       (v_cnt),
        .wrap      (v_wrap),
        .in_sync   (v_sync),
        .in_active (v_act)
    );

    // v_wrap only fires on the last pixel of the frame (h and v both at total-1).
    assign cfg_ok     = vga_axis_legal(vga_axis_t'(cfg_h)) && vga_axis_legal(vga_axis_t'(cfg_v));
    assign cfg_ready  = (shd_state == SHD_EMPTY);
    assign cfg_accept = cfg_valid && cfg_ready;
    assign apply_edge = !en || v_wrap;

    // An accept can only happen while empty, so a same-edge apply sees the
    // empty shadow and the new set waits for the next boundary.
    always_comb begin
        shd_state_d = shd_state;
        load_shd    = 1'b0;
        load_live   = 1'b0;
        case (shd_state)
            SHD_EMPTY: begin
                if (cfg_accept && cfg_ok) begin
                    load_shd    = 1'b1;
                    shd_state_d = SHD_FULL;
                end
            end
            SHD_FULL: begin
                if (apply_edge) begin
                    load_live   = 1'b1;
                    shd_state_d = SHD_EMPTY;
                end
            end
            default: shd_state_d = SHD_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_state <= SHD_EMPTY;
        end else begin
            shd_state <= shd_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_h  <= H_RST;
            live_v  <= V_RST;
            shd_h   <= '0;
            shd_v   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_accept && !cfg_ok;
            if (load_live) begin
                live_h <= shd_h;
                live_v <= shd_v;
            end
            if (load_shd) begin
                shd_h <= vga_axis_t'(cfg_h);
                shd_v <= vga_axis_t'(cfg_v);
            end
        end
    end

    // Outputs describe the counter state of the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (en && h_sync) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (en && v_sync) ? SYNC_POL : ~SYNC_POL;
            de          <= en && h_act && v_act;
            pix_x       <= h_cnt;
            pix_y       <= v_cnt;
            frame_start <= en && (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: cycle model for all outputs plus table-driven
// config vectors and hand-checked frame/line measurements.
module tb_vga_timing_ctrl;

    typedef struct packed {
        logic [10:0] a;
        logic [10:0] ss;
        logic [10:0] se;
        logic [10:0] t;
    } ax_t;

    typedef struct {
        ax_t h;
        ax_t v;
        bit  err;
        bit  rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, en, cfg_valid;
    logic        cfg_ready, cfg_err, hsync, vsync, de, frame_start;
    logic [43:0] cfg_h, cfg_v;
    logic [10:0] pix_x, pix_y;

    int    checks = 0;
    int    failures = 0;
    int    bad = 0;
    string fm;

    ax_t mh, mv, ph, pv;
    bit  mpend, offer_ok;
    int  mx, my, ex_x, ex_y;

    vec_t tbl[7];

    always #5 clk = ~clk;

    vga_timing_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_h       (cfg_h),
        .cfg_v       (cfg_v),
        .cfg_err     (cfg_err),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start)
    );

    function automatic ax_t mk(int a, int ss, int se, int t);
        ax_t r;
        r.a = 11'(a); r.ss = 11'(ss); r.se = 11'(se); r.t = 11'(t);
        return r;
    endfunction

    task automatic chk(string n, int got, int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", n, got, exp);
        end
    endtask

    task automatic seg(string n);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: %0d cycle mismatches, first: %s", n, bad, fm);
        end
        bad = 0;
    endtask

    task automatic cmp(string n, int got, int exp);
        if (got !== exp) begin
            if (bad == 0) fm = $sformatf("%s got %0d want %0d at x=%0d y=%0d", n, got, exp, ex_x, ex_y);
            bad++;
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mpend = 0;
        mh = mk(640, 656, 752, 800);
        mv = mk(480, 490, 492, 525);
    endtask

    // One clock: predict outputs for the pre-edge state, then advance the model.
    task automatic tick();
        bit e_hs, e_vs, e_de, e_fs, e_err, acc, app;
        @(posedge clk);
        e_hs = !(en && mx >= mh.ss && mx < mh.se);
        e_vs = !(en && my >= mv.ss && my < mv.se);
        e_de = en && mx < mh.a && my < mv.a;
        e_fs = en && mx == 0 && my == 0;
        ex_x = mx; ex_y = my;
        acc  = cfg_valid && !mpend;
        app  = !en || (mx == mh.t - 1 && my == mv.t - 1);
        if (!en) begin
            mx = 0; my = 0;
        end else if (mx == mh.t - 1) begin
            mx = 0;
            my = (my == mv.t - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
        if (app && mpend) begin mh = ph; mv = pv; mpend = 0; end
        if (acc && offer_ok) begin ph = cfg_h; pv = cfg_v; mpend = 1; end
        e_err = acc && !offer_ok;
        #1;
        cmp("hsync", hsync, e_hs);
        cmp("vsync", vsync, e_vs);
        cmp("de", de, e_de);
        cmp("frame_start", frame_start, e_fs);
        cmp("pix_x", pix_x, ex_x);
        cmp("pix_y", pix_y, ex_y);
        cmp("cfg_err", cfg_err, e_err);
        cmp("cfg_ready", cfg_ready, !mpend);
    endtask

    task automatic offer(ax_t h, ax_t v, bit ok);
        cfg_h = h; cfg_v = v; offer_ok = ok; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Cycles up to and including the next frame_start, with line-0 hsync stats.
    task automatic frame_len(output int n, output int hs, output int hfirst);
        n = 0; hs = 0; hfirst = -1;
        do begin
            tick();
            n++;
            if (pix_y == 0 && !hsync) begin
                hs++;
                if (hfirst < 0) hfirst = pix_x;
            end
        end while (!frame_start && n < 2000);
    endtask

    initial begin
        int n, hs, hf, de_cnt, fs_cnt;
        ax_t sh, sv;

        sh = mk(8, 10, 12, 16);
        sv = mk(4, 5, 6, 8);
        tbl[0] = '{h: mk(8, 12, 10, 16), v: mk(4, 5, 6, 8), err: 1, rdy: 1};
        tbl[1] = '{h: mk(0, 10, 12, 16), v: mk(4, 5, 6, 8), err: 1, rdy: 1};
        tbl[2] = '{h: mk(8, 10, 12, 16), v: mk(4, 5, 6, 5), err: 1, rdy: 1};
        tbl[3] = '{h: mk(8, 10, 10, 16), v: mk(4, 5, 6, 8), err: 1, rdy: 1};
        tbl[4] = '{h: mk(8, 7, 12, 16),  v: mk(4, 5, 6, 8), err: 1, rdy: 1};
        tbl[5] = '{h: mk(1, 1, 2, 2),    v: mk(1, 1, 2, 2), err: 0, rdy: 0};
        tbl[6] = '{h: mk(20, 24, 28, 32), v: mk(10, 12, 14, 16), err: 0, rdy: 0};

        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_h = '0; cfg_v = '0; offer_ok = 0;
        model_reset();
        #12;
        chk("reset hsync", hsync, 1);
        chk("reset vsync", vsync, 1);
        chk("reset de", de, 0);
        chk("reset frame_start", frame_start, 0);
        chk("reset cfg_ready", cfg_ready, 1);
        chk("reset cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        en = 1'b1;

        // Default 640x480 timing over the first lines.
        hs = 0; hf = -1; de_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 1460; i++) begin
            tick();
            if (pix_y == 0) begin
                if (!hsync) begin hs++; if (hf < 0) hf = pix_x; end
                if (de) de_cnt++;
            end
            if (frame_start) fs_cnt++;
        end
        seg("default timing model");
        chk("default hsync width", hs, 96);
        chk("default hsync first x", hf, 656);
        chk("default de width", de_cnt, 640);
        chk("default frame_start count", fs_cnt, 1);

        // en low for 3 cycles mid-line, inside the hsync window.
        en = 1'b0;
        tick();
        chk("en0 hsync deasserted", hsync, 1);
        chk("en0 de", de, 0);
        chk("en0 frame_start", frame_start, 0);
        tick();
        chk("en0 pix_x cleared", pix_x, 0);
        tick();
        en = 1'b1;
        tick();
        chk("reenable frame_start", frame_start, 1);
        chk("reenable pix_x", pix_x, 0);
        tick();
        chk("reenable pix_x step", pix_x, 1);
        seg("en drop model");

        // Config legality table, applied while stopped.
        en = 1'b0;
        foreach (tbl[i]) begin
            offer(tbl[i].h, tbl[i].v, !tbl[i].err);
            chk($sformatf("tbl%0d cfg_err", i), cfg_err, tbl[i].err);
            chk($sformatf("tbl%0d cfg_ready", i), cfg_ready, tbl[i].rdy);
            tick();
            chk($sformatf("tbl%0d ready after", i), cfg_ready, 1);
        end
        seg("cfg table model");

        // Running on the 32x16 set loaded last from the table.
        en = 1'b1;
        frame_len(n, hs, hf);
        chk("32x16 first frame_start", n, 1);
        frame_len(n, hs, hf);
        chk("32x16 frame length", n, 512);

        // Mid-frame offer: current frame completes, next frame is 16x8.
        for (int i = 0; i < 100; i++) tick();
        offer(sh, sv, 1);
        chk("mid-frame ready drops", cfg_ready, 0);
        frame_len(n, hs, hf);
        chk("old frame finishes", n + 101, 512);
        chk("ready after apply", cfg_ready, 1);
        frame_len(n, hs, hf);
        chk("16x8 frame length", n, 128);
        chk("16x8 hsync width", hs, 2);
        chk("16x8 hsync first x", hf, 10);
        seg("boundary apply model");

        // Illegal offer mid-frame: err pulse, timing unchanged.
        for (int i = 0; i < 20; i++) tick();
        offer(mk(8, 12, 10, 16), sv, 0);
        chk("illegal cfg_err", cfg_err, 1);
        chk("illegal cfg_ready", cfg_ready, 1);
        tick();
        chk("illegal err one cycle", cfg_err, 0);
        frame_len(n, hs, hf);
        frame_len(n, hs, hf);
        chk("after illegal frame length", n, 128);
        seg("illegal offer model");

        // Offer on the last-pixel edge: waits one whole frame.
        n = 0;
        while (!(mx == 15 && my == 7) && n < 300) begin tick(); n++; end
        chk("reached last pixel", mx * 100 + my, 1507);
        offer(mk(4, 5, 6, 8), mk(2, 3, 4, 4), 1);
        chk("last-pixel accept ready", cfg_ready, 0);
        frame_len(n, hs, hf);
        chk("last-pixel next frame_start", n, 1);
        frame_len(n, hs, hf);
        chk("frame after last-pixel accept", n, 128);
        frame_len(n, hs, hf);
        chk("8x4 frame length", n, 32);
        seg("last-pixel accept model");

        // Async reset mid-frame with a config pending.
        for (int i = 0; i < 10; i++) tick();
        offer(sh, sv, 1);
        chk("pending before reset", cfg_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst hsync", hsync, 1);
        chk("async rst vsync", vsync, 1);
        chk("async rst de", de, 0);
        chk("async rst pix_x", pix_x, 0);
        chk("async rst pix_y", pix_y, 0);
        chk("async rst cfg_ready", cfg_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 800; i++) tick();
        chk("post-reset pix_x 799", pix_x, 799);
        tick();
        chk("post-reset wrap pix_x", pix_x, 0);
        chk("post-reset wrap pix_y", pix_y, 1);
        chk("post-reset cfg_ready", cfg_ready, 1);
        seg("post-reset model");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
